mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a shared 32x8 memory.
// Ports: clk, rst (async, active-low); cpu_* = port 0 (req/we/addr/wdata in,
// ack/rdata out); host_* = port 1 (same shape); mem_rd/mem_wr/mem_addr/
// mem_wdata = memory command, mem_rdata = memory data one cycle after mem_rd;
// busy = FSM not in IDLE. Define MEM_ARBITER_HOST_LOCK_EN to add host_lock,
// which masks cpu_req in IDLE so only the host is granted.
module mem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
`ifdef MEM_ARBITER_HOST_LOCK_EN
  input  logic          host_lock,
`endif
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, win_q, win_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, host_rdata_q, host_rdata_d;
  logic cpu_ack_q, cpu_ack_d, host_ack_q, host_ack_d;
  logic mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, busy_q, busy_d;
  logic cpu_v, grant_host;
`ifdef MEM_ARBITER_HOST_LOCK_EN
  assign cpu_v = cpu_req & ~host_lock;
`else
  assign cpu_v = cpu_req;
`endif
  // rr_q=1 means the host was granted last, so the CPU wins the next contention
  assign grant_host = host_req & (~cpu_v | ~rr_q);
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    unique case (state_q)
      IDLE: if (cpu_v | host_req) begin
        state_d  = ACCESS;
        win_d    = grant_host;
        rr_d     = grant_host;
        we_d     = grant_host ? host_we : cpu_we;
        addr_d   = grant_host ? host_addr : cpu_addr;
        wdata_d  = grant_host ? host_wdata : cpu_wdata;
        mem_rd_d = ~we_d;
        mem_wr_d = we_d;
      end
      ACCESS: begin
        state_d    = RESP;
        cpu_ack_d  = ~win_q;
        host_ack_d = win_q;
      end
      RESP: begin
        state_d      = IDLE;
        cpu_rdata_d  = (~we_q & ~win_q) ? mem_rdata : cpu_rdata_q;
        host_rdata_d = (~we_q & win_q) ? mem_rdata : host_rdata_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= busy_d;
    end
  end
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus scoreboard bench for mem_arbiter with a 32x8 memory model.
module tb_mem_arbiter;
  logic clk = 0, rst = 0;
  logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
  logic [4:0] cpu_addr = 0, host_addr = 0, mem_addr;
  logic [7:0] cpu_wdata = 0, host_wdata = 0, cpu_rdata, host_rdata, mem_wdata;
  logic [7:0] mem_rdata = 0;
  logic cpu_ack, host_ack, mem_rd, mem_wr, busy;
`ifdef MEM_ARBITER_HOST_LOCK_EN
  logic host_lock = 0;
`endif
  int checks = 0, failures = 0;

  mem_arbiter #(.AW(5), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
`ifdef MEM_ARBITER_HOST_LOCK_EN
    .host_lock(host_lock),
`endif
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  logic [7:0] shadow [32];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] = mem_wdata;
  end

  typedef struct {bit port; bit rd; logic [7:0] data;} sb_t;
  sb_t q[$];
  logic [7:0] m_cpu = 0, m_host = 0;
  bit pend = 0;

  typedef struct {
    bit cr; bit cw; logic [4:0] ca; logic [7:0] cd;
    bit hr; bit hw; logic [4:0] ha; logic [7:0] hd;
    bit hf;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (pend) begin
      chk(cpu_rdata == m_cpu, "cpu_rdata", 64'(cpu_rdata), 64'(m_cpu));
      chk(host_rdata == m_host, "host_rdata", 64'(host_rdata), 64'(m_host));
      pend = 0;
    end
    if (cpu_ack || host_ack) begin
      chk(!(cpu_ack && host_ack), "single_ack", 64'({cpu_ack, host_ack}), 64'(1));
      chk(q.size() != 0, "ack_expected", 64'(q.size()), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(host_ack == e.port, "ack_port", 64'(host_ack), 64'(e.port));
        if (e.rd) begin
          if (e.port) m_host = e.data;
          else m_cpu = e.data;
        end
        pend = 1;
      end
    end
    chk(!(mem_rd && mem_wr), "rd_wr_exclusive", 64'({mem_rd, mem_wr}), 64'(0));
  end

  task automatic push_exp(input bit port, input bit we, input logic [4:0] a, input logic [7:0] d);
    sb_t e;
    e.port = port;
    e.rd = !we;
    e.data = shadow[a];
    if (we) shadow[a] = d;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    logic [63:0] v;
    v = 64'({cpu_ack, host_ack, busy, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_rdata, host_rdata});
    chk(v == 0, name, v, 64'(0));
  endtask

  task automatic do_reset();
    rst = 0;
    m_cpu = 0;
    m_host = 0;
    pend = 0;
    q.delete();
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    rst = 1;
    @(negedge clk);
    check_zero("reset_release");
  endtask

  task automatic apply(input vec_t v);
    int cc = 0, hc = 0, f, s;
    bit fw;
    logic [4:0] fa;
    logic [7:0] fd;
    if (v.hf) begin
      if (v.hr) push_exp(1, v.hw, v.ha, v.hd);
      if (v.cr) push_exp(0, v.cw, v.ca, v.cd);
    end else begin
      if (v.cr) push_exp(0, v.cw, v.ca, v.cd);
      if (v.hr) push_exp(1, v.hw, v.ha, v.hd);
    end
    fw = v.hf ? v.hw : v.cw;
    fa = v.hf ? v.ha : v.ca;
    fd = v.hf ? v.hd : v.cd;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    host_req = v.hr; host_we = v.hw; host_addr = v.ha; host_wdata = v.hd;
    for (int c = 1; c <= 20 && (cpu_req || host_req); c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk(mem_wr == fw && mem_rd == !fw, "access_strobe", 64'({mem_wr, mem_rd}), 64'({fw, !fw}));
        chk(mem_addr == fa, "access_addr", 64'(mem_addr), 64'(fa));
        if (fw) chk(mem_wdata == fd, "access_wdata", 64'(mem_wdata), 64'(fd));
      end
      if (cpu_ack) begin cc = c; cpu_req = 0; end
      if (host_ack) begin hc = c; host_req = 0; end
    end
    f = v.hf ? hc : cc;
    s = v.hf ? cc : hc;
    chk(f == 2, "first_ack_cycle", 64'(f), 64'(2));
    if (v.cr && v.hr) chk(s == 5, "second_ack_cycle", 64'(s), 64'(5));
    cpu_req = 0;
    host_req = 0;
    @(negedge clk);
    chk(busy == 0, "idle_after_txn", 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    tv[0]  = '{0, 0, 5'd0,  8'h00, 1, 1, 5'd5,  8'h0A, 1};
    tv[1]  = '{0, 0, 5'd0,  8'h00, 1, 0, 5'd5,  8'h00, 1};
    tv[2]  = '{1, 1, 5'd6,  8'h05, 0, 0, 5'd0,  8'h00, 0};
    tv[3]  = '{1, 0, 5'd6,  8'h00, 0, 0, 5'd0,  8'h00, 0};
    tv[4]  = '{1, 0, 5'd5,  8'h00, 1, 1, 5'd3,  8'h33, 1};
    tv[5]  = '{1, 0, 5'd0,  8'h00, 1, 1, 5'd0,  8'hA5, 1};
    tv[6]  = '{1, 1, 5'd1,  8'h11, 1, 0, 5'd1,  8'h00, 1};
    tv[7]  = '{0, 0, 5'd0,  8'h00, 1, 0, 5'd3,  8'h00, 1};
    tv[8]  = '{1, 1, 5'd3,  8'hC3, 1, 0, 5'd3,  8'h00, 0};
    tv[9]  = '{1, 0, 5'd1,  8'h00, 1, 1, 5'd1,  8'h22, 0};
    tv[10] = '{1, 1, 5'd31, 8'hFF, 0, 0, 5'd0,  8'h00, 0};
    tv[11] = '{0, 0, 5'd0,  8'h00, 1, 0, 5'd31, 8'h00, 1};
    do_reset();
    for (int i = 0; i < 12; i++) apply(tv[i]);

    // read deasserted during ACCESS still completes
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd6;
    push_exp(0, 0, 5'd6, 8'h00);
    @(negedge clk);
    chk(mem_rd && mem_addr == 5'd6, "drop_req_access", 64'({mem_rd, mem_addr}), 64'({1'b1, 5'd6}));
    cpu_req = 0;
    @(negedge clk);
    chk(cpu_ack == 1, "drop_req_ack", 64'(cpu_ack), 64'(1));
    @(negedge clk);
    chk(busy == 0, "drop_req_idle", 64'(busy), 64'(0));

    // reset during ACCESS of a host write drops it
    host_req = 1; host_we = 1; host_addr = 5'd7; host_wdata = 8'h77;
    @(negedge clk);
    chk(mem_wr == 1, "abort_mem_wr_high", 64'(mem_wr), 64'(1));
    rst = 0;
    m_cpu = 0;
    m_host = 0;
    #1;
    chk(mem_wr == 0, "abort_mem_wr_async", 64'(mem_wr), 64'(0));
    chk(busy == 0, "abort_busy_async", 64'(busy), 64'(0));
    host_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk(!cpu_ack && !host_ack, "abort_no_ack", 64'({cpu_ack, host_ack}), 64'(0));
    end
    rst = 1;
    @(negedge clk);
    check_zero("abort_outputs_zero");
    apply('{1, 0, 5'd7, 8'h00, 0, 0, 5'd0, 8'h00, 0});

    // continuous contention after reset: CPU, host, CPU, host every 3 cycles
    do_reset();
    push_exp(0, 0, 5'd0, 8'h00);
    push_exp(1, 0, 5'd1, 8'h00);
    push_exp(0, 0, 5'd0, 8'h00);
    push_exp(1, 0, 5'd1, 8'h00);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd0;
    host_req = 1; host_we = 0; host_addr = 5'd1;
    n = 0;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(negedge clk);
      if (cpu_ack || host_ack) begin
        chk(c == 2 + 3 * n, "rr_ack_cycle", 64'(c), 64'(2 + 3 * n));
        chk(host_ack == (n % 2 == 1), "rr_order", 64'(host_ack), 64'(n % 2));
        n++;
      end
    end
    chk(n == 4, "rr_ack_count", 64'(n), 64'(4));
    cpu_req = 0;
    host_req = 0;
    @(negedge clk);

`ifdef MEM_ARBITER_HOST_LOCK_EN
    host_lock = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_ack) n++;
    end
    chk(n == 0, "lock_no_cpu_ack", 64'(n), 64'(0));
    push_exp(0, 0, 5'd3, 8'h00);
    host_lock = 0;
    n = 0;
    for (int c = 1; c <= 3 && n == 0; c++) begin
      @(negedge clk);
      if (cpu_ack) n = c;
    end
    chk(n != 0 && n <= 3, "unlock_cpu_ack", 64'(n), 64'(2));
    cpu_req = 0;
    @(negedge clk);
    @(negedge clk);
`endif

    chk(q.size() == 0, "scoreboard_empty", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
